// File: rtl/textmode_pkg.sv
// Shared types and default geometry for the text-mode line renderer.
package textmode_pkg;

  localparam int DEF_COLS      = 80;
  localparam int DEF_ROWS      = 30;
  localparam int DEF_GLYPH_W   = 8;
  localparam int DEF_GLYPH_H   = 8;
  localparam int DEF_SCALE_Y   = 2;
  localparam int DEF_LINE_W    = 640;
  localparam int DEF_CHAR_BASE = 32;
  localparam int DEF_NGLYPH    = 96;
  localparam int DEF_CORDW     = 16;
  localparam int DEF_PIXW      = 4;

  typedef enum logic [2:0] {IDLE, CHAR, FONT, LATCH, PIX, TAIL, FIN} state_t;

  typedef struct packed {
    logic [3:0] bg;
    logic [3:0] fg;
  } attr_t;

  // Counter width that stays legal when the count collapses to 1.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/textmode_line_renderer_glyph_serializer.sv
// Loads one glyph row and shifts it out MSB first, flagging the last pixel.
module glyph_serializer
  import textmode_pkg::*;
#(
  parameter int GLYPH_W = DEF_GLYPH_W
) (
  input  logic               clk_sys,
  input  logic               rst_sys,
  input  logic               i_load,
  input  logic               i_shift,
  input  logic [GLYPH_W-1:0] i_data,
  output logic               o_pixel,
  output logic               o_last
);

  localparam int CW = clog2_min1(GLYPH_W);

  logic [GLYPH_W-1:0] r_shift;
  logic [CW-1:0]      r_cnt;

  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_load) begin
      r_shift <= i_data;
      r_cnt   <= CW'(GLYPH_W - 1);
    end else if (i_shift) begin
      r_shift <= r_shift << 1;
      r_cnt   <= r_cnt - 1'b1;
    end
  end

  assign o_pixel = r_shift[GLYPH_W-1];
  assign o_last  = (r_cnt == '0);

endmodule

// File: rtl/textmode_line_renderer.sv
// Renders one scanline of the text array into the line buffer.
// Optional per-character colour attributes: define TEXTMODE_ATTR_EN.
module textmode_line_renderer
  import textmode_pkg::*;
#(
  parameter int COLS      = DEF_COLS,
  parameter int ROWS      = DEF_ROWS,
  parameter int GLYPH_W   = DEF_GLYPH_W,
  parameter int GLYPH_H   = DEF_GLYPH_H,
  parameter int SCALE_Y   = DEF_SCALE_Y,
  parameter int LINE_W    = DEF_LINE_W,
  parameter int CHAR_BASE = DEF_CHAR_BASE,
  parameter int NGLYPH    = DEF_NGLYPH,
  parameter int CORDW     = DEF_CORDW,
  parameter int PIXW      = DEF_PIXW
) (
  input  logic                               clk_sys,
  input  logic                               rst_sys,
  input  logic                               start,
  input  logic signed [CORDW-1:0]            line_y,
  output logic                               busy,
  output logic                               done,
  output logic [$clog2(COLS*ROWS)-1:0]       cm_addr,
  input  logic [15:0]                        cm_data,
  output logic [$clog2(NGLYPH*GLYPH_H)-1:0]  fm_addr,
  input  logic [GLYPH_W-1:0]                 fm_data,
  output logic                               lb_we,
  output logic [$clog2(LINE_W)-1:0]          lb_addr,
  output logic [PIXW-1:0]                    lb_data
);

  localparam int CMW  = $clog2(COLS*ROWS);
  localparam int FAW  = $clog2(NGLYPH*GLYPH_H);
  localparam int LAW  = $clog2(LINE_W);
  localparam int COLW = clog2_min1(COLS);
  localparam int GHW  = clog2_min1(GLYPH_H);
  localparam int YSH  = $clog2(SCALE_Y);
  localparam int TSH  = $clog2(GLYPH_H*SCALE_Y);

  state_t          r_state;
  state_t          w_next;
  logic [LAW-1:0]  r_x;
  logic [COLW-1:0] r_col;
  logic [CMW-1:0]  r_cm_addr;
  logic [FAW-1:0]  r_fm_addr;
  logic [GHW-1:0]  r_grow;
  logic            r_valid;

  logic [CORDW-1:0] w_trow;
  logic [GHW-1:0]   w_grow;
  logic             w_blank;
  logic [CMW-1:0]   w_row_base;
  logic [7:0]       w_idx;
  logic             w_in_range;
  logic [FAW-1:0]   w_fm_calc;
  logic             w_load;
  logic             w_shift;
  logic             w_pixel;
  logic             w_last;
  logic             w_col_last;
  logic             w_unused_bits;

  // Line decode; negative lines are caught by the sign bit before trow is trusted.
  assign w_trow     = $unsigned(line_y) >> TSH;
  assign w_grow     = GHW'($unsigned(line_y) >> YSH);
  assign w_blank    = line_y[CORDW-1] | (w_trow >= CORDW'(ROWS));
  assign w_row_base = CMW'(w_trow * CORDW'(COLS));

  // Codes below CHAR_BASE wrap to large indices, so one compare rejects both ends.
  assign w_idx      = cm_data[7:0] - 8'(CHAR_BASE);
  assign w_in_range = (32'(w_idx) < NGLYPH);
  assign w_fm_calc  = FAW'(w_idx) * FAW'(GLYPH_H) + FAW'(r_grow);
  assign w_col_last = (r_col == COLW'(COLS - 1));

  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_shift = 1'b0;
    lb_we   = 1'b0;
    case (r_state)
      IDLE:  w_next = IDLE;
      CHAR:  w_next = FONT;
      FONT:  w_next = LATCH;
      LATCH: begin
        w_load = 1'b1;
        w_next = PIX;
      end
      PIX: begin
        lb_we   = 1'b1;
        w_shift = 1'b1;
        if (w_last) begin
          if (w_col_last)
            w_next = (r_x == LAW'(LINE_W - 1)) ? FIN : TAIL;
          else
            w_next = CHAR;
        end
      end
      TAIL: begin
        lb_we = 1'b1;
        if (r_x == LAW'(LINE_W - 1)) w_next = FIN;
      end
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
    // A new request always wins, including in FIN where done has already pulsed.
    if (start) w_next = w_blank ? TAIL : CHAR;
  end

`ifdef TEXTMODE_ATTR_EN
  attr_t r_attr;

  always_ff @(posedge clk_sys) begin
    if (rst_sys)
      r_attr <= '0;
    else if (!start && r_state == FONT)
      r_attr <= attr_t'(cm_data[15:8]);
  end

  always_comb begin
    lb_data = '0;
    if (r_state == PIX) lb_data = w_pixel ? PIXW'(r_attr.fg) : PIXW'(r_attr.bg);
  end

  assign w_unused_bits = ^line_y;
`else
  always_comb begin
    lb_data = '0;
    if (r_state == PIX && w_pixel) lb_data = '1;
  end

  assign w_unused_bits = ^{line_y, cm_data[15:8]};
`endif

  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      r_state   <= IDLE;
      r_x       <= '0;
      r_col     <= '0;
      r_cm_addr <= '0;
      r_fm_addr <= '0;
      r_grow    <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (start) begin
        r_x    <= '0;
        r_col  <= '0;
        r_grow <= w_grow;
        if (!w_blank) r_cm_addr <= w_row_base;
      end else begin
        if (lb_we) r_x <= r_x + 1'b1;
        if (r_state == FONT) begin
          r_valid <= w_in_range;
          if (w_in_range) r_fm_addr <= w_fm_calc;
        end
        if (r_state == PIX && w_last && !w_col_last) begin
          r_col     <= r_col + 1'b1;
          r_cm_addr <= r_cm_addr + 1'b1;
        end
      end
    end
  end

  glyph_serializer #(.GLYPH_W(GLYPH_W)) u_ser (
    .clk_sys (clk_sys),
    .rst_sys (rst_sys),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  (r_valid ? fm_data : '0),
    .o_pixel (w_pixel),
    .o_last  (w_last)
  );

  // The font address is presented during FONT so the ROM returns the row in LATCH.
  assign fm_addr = (r_state == FONT && w_in_range) ? w_fm_calc : r_fm_addr;
  assign cm_addr = r_cm_addr;
  assign lb_addr = r_x;
  assign busy    = (r_state != IDLE) && (r_state != FIN);
  assign done    = (r_state == FIN);

endmodule

// File: tb/tb_textmode_line_renderer.sv
// Directed bench for textmode_line_renderer: default geometry plus a LINE_W=648 instance.
module tb_textmode_line_renderer;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic               rst_sys, start;
  logic signed [15:0] line_y;
  logic busy, done, lb_we, busy2, done2, lb_we2;
  logic [11:0] cm_addr, cm_addr2;
  logic [15:0] cm_data, cm_data2;
  logic [9:0]  fm_addr, fm_addr2, lb_addr, lb_addr2;
  logic [7:0]  fm_data, fm_data2;
  logic [3:0]  lb_data, lb_data2;

  logic [15:0] cram [0:4095];
  logic [7:0]  from [0:1023];

  int checks = 0;
  int fails  = 0;

  int wrCount, orderErr, doneCount, busyCount, cmChanges, fmChanges;
  int wrCount2, orderErr2, doneCount2, tailCnt2, tailBad2;
  logic [11:0] cmFirst, cmLast, lastCm;
  logic [9:0]  fmFirst, fmLast, lastFm, expAddr, expAddr2, lastAddr2;
  logic [3:0]  pix [0:639];

  textmode_line_renderer dut (
    .clk_sys(clk_sys), .rst_sys(rst_sys), .start(start), .line_y(line_y),
    .busy(busy), .done(done), .cm_addr(cm_addr), .cm_data(cm_data),
    .fm_addr(fm_addr), .fm_data(fm_data), .lb_we(lb_we), .lb_addr(lb_addr), .lb_data(lb_data)
  );

  textmode_line_renderer #(.LINE_W(648)) dut2 (
    .clk_sys(clk_sys), .rst_sys(rst_sys), .start(start), .line_y(line_y),
    .busy(busy2), .done(done2), .cm_addr(cm_addr2), .cm_data(cm_data2),
    .fm_addr(fm_addr2), .fm_data(fm_data2), .lb_we(lb_we2), .lb_addr(lb_addr2), .lb_data(lb_data2)
  );

  always @(posedge clk_sys) begin
    cm_data  <= cram[cm_addr];
    fm_data  <= from[fm_addr];
    cm_data2 <= cram[cm_addr2];
    fm_data2 <= from[fm_addr2];
  end

  // Observe both DUTs away from the active edge.
  always @(negedge clk_sys) begin
    if (lb_we) begin
      if (lb_addr !== expAddr) orderErr++;
      expAddr = lb_addr + 10'd1;
      if (lb_addr < 10'd640) pix[lb_addr] = lb_data;
      else orderErr++;
      wrCount++;
    end
    if (done) doneCount++;
    if (busy) busyCount++;
    if (cm_addr !== lastCm) begin
      if (cmChanges == 0) cmFirst = cm_addr;
      cmLast = cm_addr;
      lastCm = cm_addr;
      cmChanges++;
    end
    if (fm_addr !== lastFm) begin
      if (fmChanges == 0) fmFirst = fm_addr;
      fmLast = fm_addr;
      lastFm = fm_addr;
      fmChanges++;
    end
    if (lb_we2) begin
      if (lb_addr2 !== expAddr2) orderErr2++;
      expAddr2 = lb_addr2 + 10'd1;
      lastAddr2 = lb_addr2;
      if (lb_addr2 >= 10'd640) begin
        tailCnt2++;
        if (lb_data2 !== 4'h0) tailBad2++;
      end
      wrCount2++;
    end
    if (done2) doneCount2++;
  end

  task automatic clearCounters();
    wrCount = 0; orderErr = 0; doneCount = 0; busyCount = 0; cmChanges = 0; fmChanges = 0;
    wrCount2 = 0; orderErr2 = 0; doneCount2 = 0; tailCnt2 = 0; tailBad2 = 0;
    expAddr = 0; expAddr2 = 0; lastAddr2 = 0;
    for (int i = 0; i < 640; i++) pix[i] = 4'h5;
  endtask

  task automatic applyStimulus(input logic signed [15:0] y);
    @(posedge clk_sys); #1;
    line_y = y;
    start  = 1'b1;
    @(posedge clk_sys); #1;
    start = 1'b0;
    clearCounters();
  endtask

  task automatic waitDone(input int maxCycles);
    for (int i = 0; i < maxCycles && doneCount == 0; i++) begin
      @(negedge clk_sys); #1;
    end
    repeat (12) @(negedge clk_sys);
  endtask

  function automatic int patternErrors();
    int n = 0;
    for (int i = 0; i < 640; i++)
      if (pix[i] !== ((i % 8 == 0 || i % 8 == 7) ? 4'hF : 4'h0)) n++;
    return n;
  endfunction

  function automatic int nonZero(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (pix[i] !== 4'h0) n++;
    return n;
  endfunction

  task automatic test_reset();
    rst_sys = 1'b1;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
    checks++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL reset_done: got %b, expected 0", done); end
    checks++; if (lb_we !== 1'b0) begin fails++; $display("[TB] FAIL reset_lb_we: got %b, expected 0", lb_we); end
    checks++; if (lb_addr !== 10'd0) begin fails++; $display("[TB] FAIL reset_lb_addr: got %0d, expected 0", lb_addr); end
    checks++; if (lb_data !== 4'd0) begin fails++; $display("[TB] FAIL reset_lb_data: got %0h, expected 0", lb_data); end
    checks++; if (cm_addr !== 12'd0) begin fails++; $display("[TB] FAIL reset_cm_addr: got %0d, expected 0", cm_addr); end
    checks++; if (fm_addr !== 10'd0) begin fails++; $display("[TB] FAIL reset_fm_addr: got %0d, expected 0", fm_addr); end
    @(posedge clk_sys); #1;
    rst_sys = 1'b0;
  endtask

  task automatic test_basic();
    applyStimulus(16'sd0);
    waitDone(1200);
    checks++; if (wrCount !== 640) begin fails++; $display("[TB] FAIL basic_writes: got %0d, expected 640", wrCount); end
    checks++; if (orderErr !== 0) begin fails++; $display("[TB] FAIL basic_order: got %0d bad addresses, expected 0", orderErr); end
    checks++; if (doneCount !== 1) begin fails++; $display("[TB] FAIL basic_done: got %0d pulses, expected 1", doneCount); end
    checks++; if (busyCount !== 880) begin fails++; $display("[TB] FAIL basic_busy: got %0d cycles, expected 880", busyCount); end
    checks++; if (patternErrors() !== 0) begin fails++; $display("[TB] FAIL basic_pattern: got %0d wrong pixels, expected 0", patternErrors()); end
    checks++; if (pix[639] !== 4'hF) begin fails++; $display("[TB] FAIL basic_last_pixel: got %0h, expected f", pix[639]); end
  endtask

  task automatic test_row_select();
    int ones = 0;
    applyStimulus(16'sd37);
    waitDone(1200);
    for (int i = 0; i < 640; i++) if (pix[i] === 4'hF) ones++;
    checks++; if (cmChanges !== 80) begin fails++; $display("[TB] FAIL row_cm_count: got %0d, expected 80", cmChanges); end
    checks++; if (cmFirst !== 12'd160) begin fails++; $display("[TB] FAIL row_cm_first: got %0d, expected 160", cmFirst); end
    checks++; if (cmLast !== 12'd239) begin fails++; $display("[TB] FAIL row_cm_last: got %0d, expected 239", cmLast); end
    checks++; if (fmChanges !== 80) begin fails++; $display("[TB] FAIL row_fm_count: got %0d, expected 80", fmChanges); end
    checks++; if (fmFirst !== 10'd2) begin fails++; $display("[TB] FAIL row_fm_first: got %0d, expected 2", fmFirst); end
    checks++; if (fmLast !== 10'd634) begin fails++; $display("[TB] FAIL row_fm_last: got %0d, expected 634", fmLast); end
    checks++; if (pix[26] !== 4'hF) begin fails++; $display("[TB] FAIL row_pix26: got %0h, expected f", pix[26]); end
    checks++; if (pix[30] !== 4'h0) begin fails++; $display("[TB] FAIL row_pix30: got %0h, expected 0", pix[30]); end
    checks++; if (ones !== 4) begin fails++; $display("[TB] FAIL row_lit_count: got %0d, expected 4", ones); end
    checks++; if (wrCount !== 640) begin fails++; $display("[TB] FAIL row_writes: got %0d, expected 640", wrCount); end
  endtask

  task automatic test_blank();
    logic signed [15:0] y;
    for (int k = 0; k < 2; k++) begin
      y = (k == 0) ? 16'sd480 : -16'sd1;
      applyStimulus(y);
      waitDone(1000);
      checks++; if (wrCount !== 640) begin fails++; $display("[TB] FAIL blank_writes y=%0d: got %0d, expected 640", y, wrCount); end
      checks++; if (nonZero(0, 639) !== 0) begin fails++; $display("[TB] FAIL blank_data y=%0d: got %0d nonzero, expected 0", y, nonZero(0, 639)); end
      checks++; if (cmChanges !== 0) begin fails++; $display("[TB] FAIL blank_cm y=%0d: got %0d changes, expected 0", y, cmChanges); end
      checks++; if (fmChanges !== 0) begin fails++; $display("[TB] FAIL blank_fm y=%0d: got %0d changes, expected 0", y, fmChanges); end
      checks++; if (doneCount !== 1) begin fails++; $display("[TB] FAIL blank_done y=%0d: got %0d, expected 1", y, doneCount); end
      checks++; if (busyCount !== 640) begin fails++; $display("[TB] FAIL blank_busy y=%0d: got %0d, expected 640", y, busyCount); end
      checks++; if (orderErr !== 0) begin fails++; $display("[TB] FAIL blank_order y=%0d: got %0d, expected 0", y, orderErr); end
    end
  endtask

  task automatic test_bad_code();
    cram[5] = 16'h0010;
    applyStimulus(16'sd0);
    waitDone(1200);
    checks++; if (fmChanges !== 1) begin fails++; $display("[TB] FAIL bad10_fm: got %0d changes, expected 1", fmChanges); end
    checks++; if (nonZero(40, 47) !== 0) begin fails++; $display("[TB] FAIL bad10_pixels: got %0d nonzero, expected 0", nonZero(40, 47)); end
    checks++; if (pix[39] !== 4'hF) begin fails++; $display("[TB] FAIL bad10_pix39: got %0h, expected f", pix[39]); end
    checks++; if (pix[48] !== 4'hF) begin fails++; $display("[TB] FAIL bad10_pix48: got %0h, expected f", pix[48]); end
    checks++; if (wrCount !== 640) begin fails++; $display("[TB] FAIL bad10_writes: got %0d, expected 640", wrCount); end
    cram[5] = 16'h0080;
    applyStimulus(16'sd0);
    waitDone(1200);
    checks++; if (fmChanges !== 0) begin fails++; $display("[TB] FAIL bad80_fm: got %0d changes, expected 0", fmChanges); end
    checks++; if (nonZero(40, 47) !== 0) begin fails++; $display("[TB] FAIL bad80_pixels: got %0d nonzero, expected 0", nonZero(40, 47)); end
    cram[5] = 16'h0041;
  endtask

  task automatic test_restart();
    applyStimulus(16'sd0);
    repeat (98) @(posedge clk_sys);
    applyStimulus(16'sd16);
    waitDone(1200);
    checks++; if (doneCount !== 1) begin fails++; $display("[TB] FAIL restart_done: got %0d, expected 1", doneCount); end
    checks++; if (wrCount !== 640) begin fails++; $display("[TB] FAIL restart_writes: got %0d, expected 640", wrCount); end
    checks++; if (orderErr !== 0) begin fails++; $display("[TB] FAIL restart_order: got %0d, expected 0", orderErr); end
    checks++; if (cmFirst !== 12'd80) begin fails++; $display("[TB] FAIL restart_cm_first: got %0d, expected 80", cmFirst); end
    checks++; if (cmLast !== 12'd159) begin fails++; $display("[TB] FAIL restart_cm_last: got %0d, expected 159", cmLast); end
    checks++; if (patternErrors() !== 0) begin fails++; $display("[TB] FAIL restart_pattern: got %0d wrong, expected 0", patternErrors()); end
    checks++; if (busyCount !== 880) begin fails++; $display("[TB] FAIL restart_busy: got %0d, expected 880", busyCount); end
  endtask

  task automatic test_back_to_back();
    logic finDone = 1'b0;
    applyStimulus(16'sd0);
    for (int i = 0; i < 1200 && !finDone; i++) begin
      @(negedge clk_sys); #1;
      finDone = done;
    end
    line_y = 16'sd16;
    start  = 1'b1;
    @(posedge clk_sys); #1;
    start = 1'b0;
    clearCounters();
    waitDone(1200);
    checks++; if (finDone !== 1'b1) begin fails++; $display("[TB] FAIL b2b_fin_done: got %b, expected 1", finDone); end
    checks++; if (wrCount !== 640) begin fails++; $display("[TB] FAIL b2b_writes: got %0d, expected 640", wrCount); end
    checks++; if (doneCount !== 1) begin fails++; $display("[TB] FAIL b2b_done: got %0d, expected 1", doneCount); end
    checks++; if (cmFirst !== 12'd80) begin fails++; $display("[TB] FAIL b2b_cm_first: got %0d, expected 80", cmFirst); end
    checks++; if (busyCount !== 880) begin fails++; $display("[TB] FAIL b2b_busy: got %0d, expected 880", busyCount); end
  endtask

  task automatic test_tail();
    applyStimulus(16'sd0);
    for (int i = 0; i < 1200 && doneCount2 == 0; i++) begin
      @(negedge clk_sys); #1;
    end
    repeat (12) @(negedge clk_sys);
    checks++; if (wrCount2 !== 648) begin fails++; $display("[TB] FAIL tail_writes: got %0d, expected 648", wrCount2); end
    checks++; if (tailCnt2 !== 8) begin fails++; $display("[TB] FAIL tail_count: got %0d, expected 8", tailCnt2); end
    checks++; if (tailBad2 !== 0) begin fails++; $display("[TB] FAIL tail_data: got %0d nonzero, expected 0", tailBad2); end
    checks++; if (lastAddr2 !== 10'd647) begin fails++; $display("[TB] FAIL tail_last_addr: got %0d, expected 647", lastAddr2); end
    checks++; if (orderErr2 !== 0) begin fails++; $display("[TB] FAIL tail_order: got %0d, expected 0", orderErr2); end
    checks++; if (doneCount2 !== 1) begin fails++; $display("[TB] FAIL tail_done: got %0d, expected 1", doneCount2); end
  endtask

  task automatic test_reset_midline();
    applyStimulus(16'sd0);
    repeat (50) @(posedge clk_sys);
    #1 rst_sys = 1'b1;
    @(posedge clk_sys); #1;
    rst_sys = 1'b0;
    clearCounters();
    repeat (30) @(negedge clk_sys);
    checks++; if (wrCount !== 0) begin fails++; $display("[TB] FAIL midreset_writes: got %0d, expected 0", wrCount); end
    checks++; if (doneCount !== 0) begin fails++; $display("[TB] FAIL midreset_done: got %0d, expected 0", doneCount); end
    checks++; if (busyCount !== 0) begin fails++; $display("[TB] FAIL midreset_busy: got %0d, expected 0", busyCount); end
    checks++; if (wrCount2 !== 0) begin fails++; $display("[TB] FAIL midreset_writes2: got %0d, expected 0", wrCount2); end
  endtask

  initial begin
    rst_sys = 1'b1;
    start   = 1'b0;
    line_y  = '0;
    lastCm  = '0;
    lastFm  = '0;
    for (int i = 0; i < 4096; i++) cram[i] = 16'h0041;
    for (int i = 0; i < 80; i++) cram[160 + i] = 16'(32 + i);
    for (int i = 0; i < 1024; i++) from[i] = 8'h00;
    from[264] = 8'h81;
    from[26]  = 8'h3C;
    clearCounters();
    $display("[TB] textmode_line_renderer directed tests");
    test_reset();
    test_basic();
    test_row_select();
    test_blank();
    test_bad_code();
    test_restart();
    test_back_to_back();
    test_tail();
    test_reset_midline();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
